ext_databus_arb: RTL
====================

# ext_databus_arb

Round-robin arbiter that merges the external databus masters of N external address generators onto the single system databus. It sits directly downstream of the external address generators and upstream of the memory/cache interface. It grants one generator at a time and passes its valid/addr/wdata/wstrb through. Each grant lasts until that generator drops valid or a configurable beat limit is reached. Read data is broadcast to all ports; only the granted port sees ready.

## Interface
- `N_PORTS`, 4: number of generator ports (2..16).
- `DATA_W`, 32: data width; strobe width is `DATA_W/8`.
- `ADDR_W`, `` `IO_ADDR_W ``: databus address width.
- `BURST_W`, 8: width of the beat counter and of `burst_max`.
- `clk`, input, 1: system clock, all state on rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `burst_max`, input, BURST_W: beats per grant before forced re-arbitration; 0 means unlimited.
- `s_valid`, input, N_PORTS: per-port request.
- `s_addr`, input, N_PORTS*ADDR_W: port i occupies bits [i*ADDR_W +: ADDR_W].
- `s_wdata`, input, N_PORTS*DATA_W: packed per port, same layout.
- `s_wstrb`, input, N_PORTS*DATA_W/8: packed per port; all-zero means read.
- `s_ready`, output, N_PORTS: one-hot or zero; high only for the granted port on a completed beat.
- `s_rdata`, output, DATA_W: equals `m_rdata`, broadcast to all ports.
- `m_valid`, output, 1: system databus request.
- `m_addr`, output, ADDR_W: system databus address.
- `m_wdata`, output, DATA_W: system databus write data.
- `m_wstrb`, output, DATA_W/8: system databus write strobe.
- `m_ready`, input, 1: system databus ready.
- `m_rdata`, input, DATA_W: system databus read data.
- `grant_id`, output, $clog2(N_PORTS): current or last granted port, for debug.

## Operation
- FSM states are IDLE and BUSY. Registers are state, `grant_id`, `last_id` and `beat_cnt`.
- IDLE:
  - `m_valid`=0 and `s_ready`=0.
  - If any `s_valid` is set, pick the first requesting port searching upward from `last_id`+1, wrapping at N_PORTS-1→0.
  - Register the pick as `grant_id`, clear `beat_cnt`, go to BUSY.
- BUSY:
  - `m_valid`=`s_valid[grant_id]`. `m_addr`, `m_wdata` and `m_wstrb` are muxed combinationally from port `grant_id`.
  - `s_ready[grant_id]`=`m_ready & m_valid`; all other bits are 0.
  - A beat is a cycle with `m_valid & m_ready`. Each beat increments `beat_cnt`, modulo 2^BURST_W.
- Leave BUSY for IDLE and set `last_id`=`grant_id` when either condition holds:
  - `s_valid[grant_id]`=0; no beat occurs that cycle.
  - A beat occurs, `burst_max`≠0, and `beat_cnt`+1 == `burst_max`.
- Once `m_valid`=1 with `m_ready`=0, the granted port holds its payload stable, as the generators pause on this condition. The arbiter never changes `grant_id` while BUSY.
- `m_ready` while `m_valid`=0 is ignored.
- Non-granted ports with `s_valid`=1 see `s_ready`=0 and must hold their request.
- A `burst_max` change takes effect on the next beat comparison. No re-latch is needed.
- `m_wstrb` is passed through unchanged. The arbiter does not distinguish reads from writes.

## Timing
- Reset values: state=IDLE, `grant_id`=0, `last_id`=N_PORTS-1 (so port 0 wins first), `beat_cnt`=0. Outputs are therefore `m_valid`=0, `s_ready`=0, `m_addr`/`m_wdata`/`m_wstrb`=port 0 values gated to 0 in IDLE.
- Request latency is 1 cycle: `s_valid` rising in cycle t gives `m_valid` in cycle t+1 when the bus was IDLE.
- Each grant change costs one IDLE bubble cycle.
- `s_ready` and `s_rdata` are combinational from `m_ready`/`m_rdata`, so response latency is 0 cycles.
- A beat and a valid drop cannot coincide. A port dropping valid after its last beat is seen one cycle later, giving one BUSY cycle with `m_valid`=0.
- Reset mid-burst: all state returns to reset values immediately (asynchronous). Any in-flight beat is discarded.

## Structure
- Shared package/header (`xversat.vh`): state encodings `ARB_IDLE`/`ARB_BUSY` and `ARB_STATES_W`; `IO_ADDR_W` comes from there.
- Sub-module `rr_pick`: combinational round-robin priority picker. Inputs are the request vector and `last_id`; outputs are `next_id` and `any`. Instantiate it once.

## Test plan
- **Single read:** port 1 `s_valid`=1, `s_addr`=0x100, wstrb=0, `m_ready` high from the 2nd BUSY cycle → `m_valid` at t+1, `m_addr`=0x100, `s_ready`=4'b0010 on the beat, `s_rdata`=`m_rdata`.
- **Round-robin:** ports 0, 2 and 3 request simultaneously, each dropping valid after 1 beat, `m_ready`=1 → grant order 0, 2, 3, each separated by one IDLE cycle.
- **Burst limit:** `burst_max`=4, ports 0 and 2 continuously valid, `m_ready`=1 → 4 beats from 0, bubble, 4 from 2, bubble, 4 from 0.
- **Unlimited:** `burst_max`=0 with port 1 streaming 300 beats while port 0 also requests → no re-arbitration until port 1 drops valid; `beat_cnt` wrap is harmless.
- **Stall:** port 3 write with wdata 0xDEADBEEF and wstrb 0xF, `m_ready` low for 5 cycles → `m_valid`, `m_addr` and `m_wdata` stable, `s_ready`=0 throughout; ready on the 6th cycle → exactly one `s_ready[3]` pulse.
- **Reset mid-burst:** assert `rst` low during BUSY on port 2 → `m_valid`=0 and `s_ready`=0 asynchronously. After release with ports 0 and 2 requesting, port 0 wins first.

Source files
------------

// File: rtl/ext_databus_arb_pkg.sv
// Shared definitions for the external databus arbiter: FSM encoding and
// the system databus address width.
package ext_databus_arb_pkg;

  localparam int IO_ADDR_W    = 32;
  localparam int ARB_STATES_W = 1;

  typedef enum logic [ARB_STATES_W-1:0] {
    ARB_IDLE = 1'b0,
    ARB_BUSY = 1'b1
  } arb_state_e;

endpackage

// File: rtl/ext_databus_arb_rr_pick.sv
// Combinational round-robin picker: first requester strictly after last_id,
// wrapping at N_PORTS-1 -> 0, so last_id itself has the lowest priority.
module rr_pick #(
  parameter int N_PORTS = 4,
  parameter int ID_W    = $clog2(N_PORTS)
) (
  input  logic [N_PORTS-1:0] req,
  input  logic [ID_W-1:0]    last_id,
  output logic [ID_W-1:0]    next_id,
  output logic               any
);

  logic [ID_W:0] idx_wide;

  // NOTE: every combinational output gets a default before the search loop,
  // otherwise a path that finds no requester would infer a latch.
  always_comb begin
    next_id  = '0;
    any      = 1'b0;
    idx_wide = '0;
    for (int k = 1; k <= N_PORTS; k++) begin
      idx_wide = {1'b0, last_id} + (ID_W+1)'(k);
      if (idx_wide >= (ID_W+1)'(N_PORTS)) idx_wide = idx_wide - (ID_W+1)'(N_PORTS);
      if (!any && req[idx_wide[ID_W-1:0]]) begin
        any     = 1'b1;
        next_id = idx_wide[ID_W-1:0];
      end
    end
  end

endmodule

// File: rtl/ext_databus_arb.sv
// Round-robin arbiter merging N generator databus masters onto one system
// databus; a grant lasts until the owner drops valid or burst_max beats.
module ext_databus_arb
  import ext_databus_arb_pkg::*;
#(
  parameter int N_PORTS = 4,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = IO_ADDR_W,
  parameter int BURST_W = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [BURST_W-1:0]            burst_max,
  input  logic [N_PORTS-1:0]            s_valid,
  input  logic [N_PORTS*ADDR_W-1:0]     s_addr,
  input  logic [N_PORTS*DATA_W-1:0]     s_wdata,
  input  logic [N_PORTS*DATA_W/8-1:0]   s_wstrb,
  output logic [N_PORTS-1:0]            s_ready,
  output logic [DATA_W-1:0]             s_rdata,
  output logic                          m_valid,
  output logic [ADDR_W-1:0]             m_addr,
  output logic [DATA_W-1:0]             m_wdata,
  output logic [DATA_W/8-1:0]           m_wstrb,
  input  logic                          m_ready,
  input  logic [DATA_W-1:0]             m_rdata,
  output logic [$clog2(N_PORTS)-1:0]    grant_id
);

  localparam int STRB_W = DATA_W/8;
  localparam int ID_W   = $clog2(N_PORTS);

  arb_state_e         state, state_nxt;
  logic [ID_W-1:0]    grant_nxt, last_id, last_nxt, pick_id;
  logic [BURST_W-1:0] beat_cnt, beat_nxt, beat_inc;
  logic               pick_any, sel_valid, beat;

  rr_pick #(.N_PORTS(N_PORTS), .ID_W(ID_W)) u_pick (
    .req     (s_valid),
    .last_id (last_id),
    .next_id (pick_id),
    .any     (pick_any)
  );

  assign s_rdata   = m_rdata;
  assign sel_valid = s_valid[grant_id];
  assign beat_inc  = beat_cnt + 1'b1;

  always_comb begin
    m_valid   = 1'b0;
    m_addr    = '0;
    m_wdata   = '0;
    m_wstrb   = '0;
    s_ready   = '0;
    beat      = 1'b0;
    state_nxt = state;
    grant_nxt = grant_id;
    last_nxt  = last_id;
    beat_nxt  = beat_cnt;
    case (state)
      ARB_IDLE: begin
        if (pick_any) begin
          grant_nxt = pick_id;
          beat_nxt  = '0;
          state_nxt = ARB_BUSY;
        end
      end
      ARB_BUSY: begin
        m_valid           = sel_valid;
        m_addr            = s_addr[int'(grant_id)*ADDR_W +: ADDR_W];
        m_wdata           = s_wdata[int'(grant_id)*DATA_W +: DATA_W];
        m_wstrb           = s_wstrb[int'(grant_id)*STRB_W +: STRB_W];
        beat              = sel_valid & m_ready;
        s_ready[grant_id] = beat;
        // A valid drop and a beat are mutually exclusive, so a drop always
        // ends the grant without counting.
        if (!sel_valid) begin
          state_nxt = ARB_IDLE;
          last_nxt  = grant_id;
        end else if (beat) begin
          beat_nxt = beat_inc;
          if (burst_max != '0 && beat_inc == burst_max) begin
            state_nxt = ARB_IDLE;
            last_nxt  = grant_id;
          end
        end
      end
      default: state_nxt = ARB_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ARB_IDLE;
      grant_id <= '0;
      last_id  <= ID_W'(N_PORTS-1);
      beat_cnt <= '0;
    end else begin
      state    <= state_nxt;
      grant_id <= grant_nxt;
      last_id  <= last_nxt;
      beat_cnt <= beat_nxt;
    end
  end

endmodule
